// File: rtl/traffic.sv
// Traffic light controller: car lamp FSM plus walker lamp.
// Optional macro TRAFFIC_WALK_BLINK_EN blinks the tail of walker green.
module traffic #(
  parameter int GREEN_T  = 10,
  parameter int LEFT_T   = 4,
  parameter int YELLOW_T = 3,
  parameter int WALK_T   = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_flag,
  output logic [3:0] o_car_traffic,
  output logic [1:0] o_walker_traffic
);

  localparam int RED_T = GREEN_T + LEFT_T + YELLOW_T;
  localparam int CW    = 10;

`ifdef TRAFFIC_WALK_BLINK_EN
  localparam int   BLINK_LO  = (WALK_T >= 4) ? WALK_T - 4 : 0;
  localparam logic BLINK_PAR = 1'(BLINK_LO % 2);
`endif

  typedef enum logic [1:0] {
    S_GREEN,
    S_LEFT,
    S_YELLOW,
    S_RED
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   last;
  logic [3:0]      car_q, car_d;
  logic [1:0]      walk_q, walk_d;

  // Terminal count of the current state and its successor.
  state_e nxt;
  always_comb begin
    last = '0;
    nxt  = S_GREEN;
    unique case (state_q)
      S_GREEN: begin
        last = CW'(GREEN_T - 1);
        nxt  = S_LEFT;
      end
      S_LEFT: begin
        last = CW'(LEFT_T - 1);
        nxt  = S_YELLOW;
      end
      S_YELLOW: begin
        last = CW'(YELLOW_T - 1);
        nxt  = S_RED;
      end
      S_RED: begin
        last = CW'(RED_T - 1);
        nxt  = S_GREEN;
      end
    endcase
  end

  // Next state, counter and lamp values; lamps derive from the
  // next state so they change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    car_d   = 4'b0010;
    walk_d  = 2'b01;
    if (i_start) begin
      if (cnt_q == last) begin
        state_d = nxt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    unique case (state_d)
      S_GREEN:  car_d = 4'b0010;
      S_LEFT:   car_d = 4'b0001;
      S_YELLOW: car_d = 4'b0100;
      S_RED:    car_d = 4'b1000;
    endcase
    if (state_d == S_RED && cnt_d < CW'(WALK_T)) begin
      walk_d = 2'b10;
`ifdef TRAFFIC_WALK_BLINK_EN
      if (cnt_d >= CW'(BLINK_LO) && cnt_d[0] != BLINK_PAR) begin
        walk_d = 2'b00;
      end
`endif
    end
  end

  // State, counter and registered lamps; i_flag picks reset phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= i_flag ? S_RED : S_GREEN;
      cnt_q   <= '0;
      car_q   <= i_flag ? 4'b1000 : 4'b0010;
      walk_q  <= i_flag ? 2'b10 : 2'b01;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      car_q   <= car_d;
      walk_q  <= walk_d;
    end
  end

  assign o_car_traffic    = car_q;
  assign o_walker_traffic = walk_q;

endmodule

// File: tb/tb_traffic.sv
// Directed bench: two opposite-phase traffic instances
// checked cycle by cycle against a hand-written timeline.
module tb_traffic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       f0, f1;
  logic [3:0] car0, car1;
  logic [1:0] walk0, walk1;

  int checks = 0;
  int errors = 0;
  int lt     = 0;
  bit ph0    = 1'b0;
  bit ph1    = 1'b1;

  always #5 clk = ~clk;

  traffic u0 (
    .clk              (clk),
    .reset_n          (rst_n),
    .i_start          (start),
    .i_flag           (f0),
    .o_car_traffic    (car0),
    .o_walker_traffic (walk0)
  );

  traffic u1 (
    .clk              (clk),
    .reset_n          (rst_n),
    .i_start          (start),
    .i_flag           (f1),
    .o_car_traffic    (car1),
    .o_walker_traffic (walk1)
  );

  // Default timeline: green 0-9, left 10-13, yellow 14-16, red 17-33.
  function automatic logic [3:0] ecar(int t);
    if (t < 10) return 4'b0010;
    if (t < 14) return 4'b0001;
    if (t < 17) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic [1:0] ewalk(int t);
    if (t < 17 || t > 28) return 2'b01;
`ifdef TRAFFIC_WALK_BLINK_EN
    if (t == 26 || t == 28) return 2'b00;
`endif
    return 2'b10;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, lt, obs, exp);
    end
  endtask

  task automatic chk_all();
    int t0, t1;
    t0 = (lt + (ph0 ? 17 : 0)) % 34;
    t1 = (lt + (ph1 ? 17 : 0)) % 34;
    chk("car0", car0, ecar(t0));
    chk("walk0", {2'b00, walk0}, {2'b00, ewalk(t0)});
    chk("car1", car1, ecar(t1));
    chk("walk1", {2'b00, walk1}, {2'b00, ewalk(t1)});
    chk("onered", {3'b000, (car0 == 4'b1000) ^ (car1 == 4'b1000)},
        4'b0001);
  endtask

  task automatic step(bit s);
    start = s;
    @(posedge clk);
    @(negedge clk);
    if (s) lt++;
    chk_all();
  endtask

  task automatic do_reset(bit a, bit b);
    @(negedge clk);
    f0    = a;
    f1    = b;
    ph0   = a;
    ph1   = b;
    rst_n = 1'b0;
    lt    = 0;
    #1;
    chk_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    f0    = 1'b0;
    f1    = 1'b1;

    // Full period plus wrap into the next green.
    do_reset(1'b0, 1'b1);
    repeat (40) step(1'b1);

    // Two-cycle pause at cycle 30 delays everything by two.
    do_reset(1'b0, 1'b1);
    repeat (30) step(1'b1);
    repeat (2) step(1'b0);
    repeat (6) step(1'b1);

    // Asynchronous reset during LEFT, with start low.
    do_reset(1'b0, 1'b1);
    repeat (11) step(1'b1);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    lt    = 0;
    #1;
    chk_all();
    @(posedge clk);
    @(negedge clk);
    chk_all();
    rst_n = 1'b1;
    start = 1'b1;
    repeat (5) step(1'b1);

    // Flag swap while running is ignored until the next reset.
    f0 = 1'b1;
    f1 = 1'b0;
    repeat (5) step(1'b1);
    do_reset(1'b1, 1'b0);
    repeat (20) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
